// File: rtl/reg_read_port_if.sv
// Operand-fetch bus between the register bank, the read port and its consumer.
// Bundles the bank snapshot, the request and result handshakes and the write bypass.
interface reg_read_port_if #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    parameter int SELW  = 3
);
    logic [NREG*WIDTH-1:0] rin;
    logic                  req_valid;
    logic                  req_ready;
    logic [SELW-1:0]       ra_sel;
    logic [SELW-1:0]       rb_sel;
    logic                  wr_en;
    logic [SELW-1:0]       wr_sel;
    logic [WIDTH-1:0]      wr_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      opa;
    logic [WIDTH-1:0]      opb;
    logic [7:0]            rd_cnt;

    // Read port side.
    modport slave (
        input  rin, req_valid, ra_sel, rb_sel, wr_en, wr_sel, wr_data, out_ready,
        output req_ready, out_valid, opa, opb, rd_cnt
    );

    // Requester / bank / consumer side.
    modport master (
        output rin, req_valid, ra_sel, rb_sel, wr_en, wr_sel, wr_data, out_ready,
        input  req_ready, out_valid, opa, opb, rd_cnt
    );
endinterface

// File: rtl/reg_read_port.sv
// Read side of the register bank: latches two register selects on request,
// fetches both operands one cycle later (forwarding a same-cycle bank write),
// and holds the snapshot with a valid/ready handshake until the consumer takes it.
module reg_read_port #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    parameter int SELW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_read_port_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [SELW-1:0]  sel_a;
    logic [SELW-1:0]  sel_b;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [7:0]       rd_cnt_q;

    logic             req_ready_c;
    logic             out_valid_c;
    logic             load_sel;
    logic             load_ops;
    logic             count;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;

    // Next-state and control decode; REQ_READY depends only on state and OUT_READY.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        next_state  = state;
        req_ready_c = 1'b0;
        out_valid_c = 1'b0;
        load_sel    = 1'b0;
        load_ops    = 1'b0;
        count       = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    load_sel   = 1'b1;
                    next_state = READ;
                end
            end
            READ: begin
                load_ops   = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                out_valid_c = 1'b1;
                req_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    count = 1'b1;
                    if (bus.req_valid) begin
                        load_sel   = 1'b1;
                        next_state = READ;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand sources: a write landing in the bank this cycle wins over the stale slice.
    always_comb begin
        src_a = bus.rin[sel_a*WIDTH +: WIDTH];
        src_b = bus.rin[sel_b*WIDTH +: WIDTH];
        if (bus.wr_en && bus.wr_sel == sel_a) src_a = bus.wr_data;
        if (bus.wr_en && bus.wr_sel == sel_b) src_b = bus.wr_data;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Select latch, operand snapshot and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a    <= '0;
            sel_b    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (load_sel) begin
                sel_a <= bus.ra_sel;
                sel_b <= bus.rb_sel;
            end
            if (load_ops) begin
                opa_q <= src_a;
                opb_q <= src_b;
            end
            if (count) rd_cnt_q <= rd_cnt_q + 8'd1;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.rd_cnt    = rd_cnt_q;

endmodule
